// File: rtl/vga_cerceve_hakemi.sv
// vga_cerceve_hakemi: write-port arbiter for the 640x480 1-bpp VGA framebuffer.
// Shares one framebuffer write port between a direct pixel requester and an
// internal rectangle-fill engine, configured and started over Wishbone.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   wb_*                               Wishbone slave (one wait state)
//   pix_req_i/x/y/dat, pix_gnt_o       direct pixel request, combinational grant
//   fb_we_o/fb_x_o/fb_y_o/fb_dat_o     registered framebuffer write port
//   done_o                             one-cycle pulse on fill completion/abort
module vga_cerceve_hakemi #(
  parameter int unsigned H_PIKSEL = 640,
  parameter int unsigned V_PIKSEL = 480,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [4:0]    wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_cyc_i,
  output logic          wb_ack_o,
  output logic [31:0]   wb_dat_o,
  input  logic          pix_req_i,
  input  logic [XW-1:0] pix_x_i,
  input  logic [YW-1:0] pix_y_i,
  input  logic          pix_dat_i,
  output logic          pix_gnt_o,
  output logic          fb_we_o,
  output logic [XW-1:0] fb_x_o,
  output logic [YW-1:0] fb_y_o,
  output logic          fb_dat_o,
  output logic          done_o
);

  typedef enum logic {BOSTA, DOLDUR} durum_t;

  durum_t        state;
  logic [XW-1:0] x0, x1, cx;
  logic [YW-1:0] y0, y1, cy;
  logic          renk;
  logic          error;
  logic          pix_won_last;   // 1: pixel won the most recent contested cycle

  logic [2:0]    idx;
  logic          bus_go, reg_wr, busy;
  logic          fill_go, pix_ok, start_cmd, abort_cmd, cfg_bad, son_piksel;
  logic [31:0]   rd_data;
  logic          unused;

  assign idx       = wb_adr_i[4:2];
  assign bus_go    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign reg_wr    = bus_go & wb_we_i & wb_sel_i[0];
  assign busy      = (state == DOLDUR);
  assign start_cmd = reg_wr & (idx == 3'd5) & wb_dat_i[0];
  assign abort_cmd = reg_wr & (idx == 3'd5) & wb_dat_i[1];

  // Round-robin: on contention the pixel wins unless it won the previous contest.
  assign pix_gnt_o = pix_req_i & (~busy | ~pix_won_last);
  assign fill_go   = busy & ~pix_gnt_o;

  assign pix_ok  = (pix_x_i < XW'(H_PIKSEL)) && (pix_y_i < YW'(V_PIKSEL));
  assign cfg_bad = (x0 > x1) || (y0 > y1) ||
                   (x1 >= XW'(H_PIKSEL)) || (y1 >= YW'(V_PIKSEL));
  assign son_piksel = (cx == x1) && (cy == y1);

  assign unused = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:XW]};

  // Register read mux
  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0:    rd_data = 32'(x0);
      3'd1:    rd_data = 32'(y0);
      3'd2:    rd_data = 32'(x1);
      3'd3:    rd_data = 32'(y1);
      3'd4:    rd_data = 32'(renk);
      3'd5:    rd_data = 32'({error, busy});
      default: rd_data = '0;
    endcase
  end

  // Bus registers, arbitration, write port and fill FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= BOSTA;
      x0           <= '0;
      y0           <= '0;
      x1           <= '0;
      y1           <= '0;
      cx           <= '0;
      cy           <= '0;
      renk         <= 1'b0;
      error        <= 1'b0;
      pix_won_last <= 1'b0;
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      fb_we_o      <= 1'b0;
      fb_x_o       <= '0;
      fb_y_o       <= '0;
      fb_dat_o     <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      wb_ack_o <= bus_go;
      if (bus_go) wb_dat_o <= rd_data;
      done_o <= 1'b0;

      // Configuration is frozen while a fill is running.
      if (reg_wr && !busy) begin
        case (idx)
          3'd0:    x0   <= wb_dat_i[XW-1:0];
          3'd1:    y0   <= wb_dat_i[YW-1:0];
          3'd2:    x1   <= wb_dat_i[XW-1:0];
          3'd3:    y1   <= wb_dat_i[YW-1:0];
          3'd4:    renk <= wb_dat_i[0];
          default: ;
        endcase
      end

      if (pix_req_i && busy) pix_won_last <= pix_gnt_o;

      // Out-of-range pixels are consumed without producing a write.
      if (pix_gnt_o) begin
        fb_we_o  <= pix_ok;
        fb_x_o   <= pix_x_i;
        fb_y_o   <= pix_y_i;
        fb_dat_o <= pix_dat_i;
      end else if (fill_go) begin
        fb_we_o  <= 1'b1;
        fb_x_o   <= cx;
        fb_y_o   <= cy;
        fb_dat_o <= renk;
      end else begin
        fb_we_o  <= 1'b0;
      end

      case (state)
        BOSTA: begin
          if (start_cmd) begin
            if (cfg_bad) begin
              error <= 1'b1;
            end else begin
              error <= 1'b0;
              cx    <= x0;
              cy    <= y0;
              state <= DOLDUR;
            end
          end
        end
        DOLDUR: begin
          if (abort_cmd) begin
            state  <= BOSTA;
            done_o <= 1'b1;
          end else if (fill_go) begin
            if (son_piksel) begin
              state  <= BOSTA;
              done_o <= 1'b1;
            end else if (cx == x1) begin
              cx <= x0;
              cy <= cy + YW'(1);
            end else begin
              cx <= cx + XW'(1);
            end
          end
        end
        default: state <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_cerceve_hakemi.sv
// Directed testbench for vga_cerceve_hakemi.
module tb_vga_cerceve_hakemi;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [4:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        pix_req_i = 1'b0;
  logic [9:0]  pix_x_i = '0;
  logic [8:0]  pix_y_i = '0;
  logic        pix_dat_i = 1'b0;
  logic        pix_gnt_o;
  logic        fb_we_o;
  logic [9:0]  fb_x_o;
  logic [8:0]  fb_y_o;
  logic        fb_dat_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int lx[$];
  int ly[$];
  int ld[$];
  int lc[$];
  int done_q[$];

  vga_cerceve_hakemi dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i),
    .wb_stb_i(wb_stb_i), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .pix_req_i(pix_req_i), .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
    .pix_dat_i(pix_dat_i), .pix_gnt_o(pix_gnt_o),
    .fb_we_o(fb_we_o), .fb_x_o(fb_x_o), .fb_y_o(fb_y_o),
    .fb_dat_o(fb_dat_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Log every framebuffer write and done pulse with the cycle it appears in.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (fb_we_o) begin
        lx.push_back(int'(fb_x_o));
        ly.push_back(int'(fb_y_o));
        ld.push_back(int'(fb_dat_o));
        lc.push_back(cyc);
      end
      if (done_o) done_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    lx.delete(); ly.delete(); ld.delete(); lc.delete(); done_q.delete();
  endtask

  function automatic int find_cyc(input int c);
    for (int i = 0; i < lc.size(); i++) if (lc[i] == c) return i;
    return -1;
  endfunction

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, output int ack_cyc);
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hf;
    wb_adr_i = {idx, 2'b00}; wb_dat_i = d;
    @(posedge clk_i); #1;
    ack_cyc = cyc;
    @(negedge clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
  endtask

  task automatic wb_read(input logic [2:0] idx, output logic [31:0] d);
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hf;
    wb_adr_i = {idx, 2'b00};
    @(posedge clk_i); #1;
    d = wb_dat_o;
    @(negedge clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i); #2;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_log();
  endtask

  task automatic config_rect(input int ax0, input int ay0, input int ax1, input int ay1, input int r);
    int c;
    wb_write(3'd0, 32'(ax0), c);
    wb_write(3'd1, 32'(ay0), c);
    wb_write(3'd2, 32'(ax1), c);
    wb_write(3'd3, 32'(ay1), c);
    wb_write(3'd4, 32'(r), c);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #23;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({wb_ack_o, wb_dat_o, pix_gnt_o, fb_we_o, fb_x_o, fb_y_o, fb_dat_o, done_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: outputs not all zero during reset");
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_log();
    wb_read(3'd5, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_kontrol: got %0h want 0", d); end
    wb_read(3'd2, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_x1: got %0h want 0", d); end
  endtask

  task automatic test_ack();
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd24;
    @(posedge clk_i); #1;
    n_tests++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'd0) begin
      n_fail++; $display("FAIL ack_first: ack %b dat %0h want 1/0", wb_ack_o, wb_dat_o);
    end
    @(posedge clk_i); #1;
    n_tests++;
    if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL ack_gap: ack %b want 0", wb_ack_o); end
    @(posedge clk_i); #1;
    n_tests++;
    if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL ack_again: ack %b want 1", wb_ack_o); end
    @(negedge clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_fill();
    int s, c;
    int ex[6] = '{2, 3, 4, 2, 3, 4};
    int ey[6] = '{3, 3, 3, 4, 4, 4};
    logic [31:0] d;
    do_reset();
    config_rect(2, 3, 4, 4, 1);
    wb_write(3'd5, 32'd1, s);
    repeat (12) @(negedge clk_i);
    n_tests++;
    if (lx.size() != 6) begin n_fail++; $display("FAIL fill_count: got %0d want 6", lx.size()); end
    for (int i = 0; i < 6 && i < lx.size(); i++) begin
      n_tests++;
      if (lx[i] != ex[i] || ly[i] != ey[i] || ld[i] != 1 || lc[i] != s + 1 + i) begin
        n_fail++;
        $display("FAIL fill_pix%0d: got (%0d,%0d,%0d)@%0d want (%0d,%0d,1)@%0d",
                 i, lx[i], ly[i], ld[i], lc[i], ex[i], ey[i], s + 1 + i);
      end
    end
    n_tests++;
    if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != s + 6)) begin
      n_fail++; $display("FAIL fill_done: %0d pulses, want one at cycle %0d", done_q.size(), s + 6);
    end
    wb_read(3'd5, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL fill_busy: got %0h want 0", d); end
    c = 0;
  endtask

  task automatic test_contention();
    int s, k, j;
    do_reset();
    config_rect(0, 0, 7, 0, 1);
    @(negedge clk_i);
    pix_req_i = 1'b1; pix_x_i = 10'd100; pix_y_i = 9'd100; pix_dat_i = 1'b0;
    wb_write(3'd5, 32'd1, s);
    repeat (20) @(negedge clk_i);
    pix_req_i = 1'b0;
    @(negedge clk_i);
    for (k = 1; k <= 17; k++) begin
      j = find_cyc(s + k);
      n_tests++;
      if (j < 0) begin
        n_fail++; $display("FAIL cont_slot%0d: no write at cycle %0d", k, s + k);
      end else if (k % 2 == 1 || k == 17) begin
        if (lx[j] != 100 || ly[j] != 100 || ld[j] != 0) begin
          n_fail++; $display("FAIL cont_slot%0d: got (%0d,%0d,%0d) want pixel (100,100,0)",
                             k, lx[j], ly[j], ld[j]);
        end
      end else begin
        if (lx[j] != k / 2 - 1 || ly[j] != 0 || ld[j] != 1) begin
          n_fail++; $display("FAIL cont_slot%0d: got (%0d,%0d,%0d) want fill (%0d,0,1)",
                             k, lx[j], ly[j], ld[j], k / 2 - 1);
        end
      end
    end
    n_tests++;
    if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != s + 16)) begin
      n_fail++; $display("FAIL cont_done: %0d pulses, want one at cycle %0d", done_q.size(), s + 16);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    @(negedge clk_i);
    pix_req_i = 1'b1; pix_x_i = 10'd640; pix_y_i = 9'd0; pix_dat_i = 1'b1;
    #1;
    n_tests++;
    if (pix_gnt_o !== 1'b1) begin n_fail++; $display("FAIL oor_x_gnt: got %b want 1", pix_gnt_o); end
    @(posedge clk_i); #1;
    n_tests++;
    if (fb_we_o !== 1'b0) begin n_fail++; $display("FAIL oor_x_we: got %b want 0", fb_we_o); end
    @(negedge clk_i);
    pix_x_i = 10'd639; pix_y_i = 9'd480;
    @(posedge clk_i); #1;
    n_tests++;
    if (fb_we_o !== 1'b0) begin n_fail++; $display("FAIL oor_y_we: got %b want 0", fb_we_o); end
    @(negedge clk_i);
    pix_y_i = 9'd479;
    @(posedge clk_i); #1;
    n_tests++;
    if (fb_we_o !== 1'b1 || fb_x_o !== 10'd639 || fb_y_o !== 9'd479 || fb_dat_o !== 1'b1) begin
      n_fail++; $display("FAIL edge_pixel: got we=%b (%0d,%0d,%b) want 1 (639,479,1)",
                         fb_we_o, fb_x_o, fb_y_o, fb_dat_o);
    end
    @(negedge clk_i);
    pix_req_i = 1'b0;
  endtask

  task automatic test_invalid();
    int s;
    logic [31:0] d;
    do_reset();
    config_rect(5, 0, 4, 0, 1);
    wb_write(3'd5, 32'd1, s);
    repeat (8) @(negedge clk_i);
    wb_read(3'd5, d);
    n_tests++;
    if (lx.size() != 0 || done_q.size() != 0 || d !== 32'd2) begin
      n_fail++; $display("FAIL inv_x0gtx1: writes %0d done %0d kontrol %0h want 0/0/2",
                         lx.size(), done_q.size(), d);
    end
    config_rect(0, 0, 640, 0, 1);
    wb_write(3'd5, 32'd1, s);
    repeat (8) @(negedge clk_i);
    wb_read(3'd5, d);
    n_tests++;
    if (lx.size() != 0 || done_q.size() != 0 || d !== 32'd2) begin
      n_fail++; $display("FAIL inv_x1_640: writes %0d done %0d kontrol %0h want 0/0/2",
                         lx.size(), done_q.size(), d);
    end
    // Single-pixel fill at the far corner is valid and clears the error flag.
    config_rect(639, 479, 639, 479, 0);
    wb_write(3'd5, 32'd1, s);
    repeat (5) @(negedge clk_i);
    wb_read(3'd5, d);
    n_tests++;
    if (lx.size() != 1 || done_q.size() != 1 || d !== 32'd0) begin
      n_fail++; $display("FAIL single_pixel: writes %0d done %0d kontrol %0h want 1/1/0",
                         lx.size(), done_q.size(), d);
    end else if (lx[0] != 639 || ly[0] != 479 || ld[0] != 0 || lc[0] != s + 1) begin
      n_fail++; $display("FAIL single_pixel: got (%0d,%0d,%0d)@%0d want (639,479,0)@%0d",
                         lx[0], ly[0], ld[0], lc[0], s + 1);
    end
  endtask

  task automatic test_abort();
    int s, c;
    logic [31:0] d;
    do_reset();
    config_rect(0, 0, 639, 0, 1);
    wb_write(3'd5, 32'd1, s);
    repeat (8) @(negedge clk_i);
    wb_write(3'd5, 32'd2, c);
    repeat (10) @(negedge clk_i);
    n_tests++;
    if (lx.size() < 10 || lx.size() > 11) begin
      n_fail++; $display("FAIL abort_count: got %0d writes want 10..11", lx.size());
    end
    n_tests++;
    if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != c)) begin
      n_fail++; $display("FAIL abort_done: %0d pulses, want one at cycle %0d", done_q.size(), c);
    end
    wb_read(3'd5, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL abort_busy: got %0h want 0", d); end
  endtask

  task automatic test_busy_ignore();
    int s, c, bad;
    logic [31:0] d;
    do_reset();
    config_rect(0, 0, 9, 0, 1);
    wb_write(3'd5, 32'd1, s);
    wb_write(3'd2, 32'd2, c);
    wb_write(3'd4, 32'd0, c);
    wb_write(3'd5, 32'd1, c);
    repeat (10) @(negedge clk_i);
    bad = 0;
    for (int i = 0; i < lx.size(); i++) if (ld[i] != 1 || lx[i] != i) bad++;
    n_tests++;
    if (lx.size() != 10 || bad != 0 || done_q.size() != 1) begin
      n_fail++; $display("FAIL busy_ignore: writes %0d bad %0d done %0d want 10/0/1",
                         lx.size(), bad, done_q.size());
    end
    wb_read(3'd2, d);
    n_tests++;
    if (d !== 32'd9) begin n_fail++; $display("FAIL busy_x1: got %0d want 9", d); end
    wb_read(3'd4, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL busy_renk: got %0d want 1", d); end
  endtask

  task automatic test_reset_mid_fill();
    int s;
    logic [31:0] d;
    clear_log();
    wb_write(3'd5, 32'd1, s);
    @(posedge clk_i); #1;
    n_tests++;
    if (fb_we_o !== 1'b1) begin n_fail++; $display("FAIL mid_active: fb_we %b want 1", fb_we_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (fb_we_o !== 1'b0 || done_o !== 1'b0 || fb_x_o !== 10'd0) begin
      n_fail++; $display("FAIL mid_reset: fb_we %b done %b x %0d want 0/0/0", fb_we_o, done_o, fb_x_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_log();
    repeat (15) @(negedge clk_i);
    n_tests++;
    if (lx.size() != 0 || done_q.size() != 0) begin
      n_fail++; $display("FAIL mid_after: writes %0d done %0d want 0/0", lx.size(), done_q.size());
    end
    wb_read(3'd5, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL mid_kontrol: got %0h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_fill();
    test_contention();
    test_out_of_range();
    test_invalid();
    test_abort();
    test_busy_ignore();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
